// File: rtl/mem_block_mover_pkg.sv
// Shared definitions for the block mover: FSM state encoding and command modes.
// Imported by the top-level engine.
package mem_defs;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_FILLW,
      ST_FIN
   } state_t;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_block_addr_gen.sv
// Word offset counter for the block mover.
// Loads start offset, steps up or down, flags the last word of the command.
module mem_block_addr_gen #(
   parameter int K = 11
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic         down,
   input  logic [K:0]   len,
   input  logic         step,
   output logic [K-1:0] off,
   output logic         last
);

   logic [K:0] cnt;
   logic [K:0] len_q;
   logic       down_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt    <= '0;
         len_q  <= '0;
         down_q <= 1'b0;
      end else if (load) begin
         cnt    <= down ? len - 1'b1 : '0;
         len_q  <= len;
         down_q <= down;
      end else if (step) begin
         cnt <= down_q ? cnt - 1'b1 : cnt + 1'b1;
      end
   end

   // Descending runs end at offset 0, ascending runs at len-1.
   always_comb begin
      last = down_q ? (cnt == '0) : (cnt == len_q - 1'b1);
      off  = cnt[K-1:0];
   end

endmodule

// File: rtl/mem_block_mover.sv
// Command-driven copy/fill engine mastering a single-port memory.
// One word per cycle for FILL, read+write pair per word for COPY.
module mem_block_mover
   import mem_defs::*;
#(
   parameter int M = 8,
   parameter int K = 11
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic         mode,
   input  logic [K-1:0] src,
   input  logic [K-1:0] dst,
   input  logic [K:0]   len,
   input  logic [M-1:0] fill_value,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [K-1:0] mem_a,
   output logic [M-1:0] mem_wd,
   output logic         mem_we,
   input  logic [M-1:0] mem_rd
);

   localparam logic [K:0] CAP = {1'b1, {K{1'b0}}};

   state_t       state;
   state_t       state_nxt;
   logic         mode_q;
   logic [K-1:0] src_q;
   logic [K-1:0] dst_q;
   logic [M-1:0] fill_q;
   logic [M-1:0] data_q;
   logic         err_q;

   logic [K:0]   src_end;
   logic [K:0]   dst_end;
   logic         len_zero;
   logic         range_bad;
   logic         desc;
   logic         accept;
   logic [K-1:0] off;
   logic         last;
   logic         step;

   // Sums fit in K+1 bits: max (2^K-1) + 2^K.
   always_comb begin
      src_end   = {1'b0, src} + len;
      dst_end   = {1'b0, dst} + len;
      len_zero  = (len == '0);
      range_bad = ((mode == MODE_COPY) && (src_end > CAP))
                  || (dst_end > CAP);
      desc      = (mode == MODE_COPY) && (dst > src);
      accept    = (state == ST_IDLE) && start;
      step      = (state == ST_WRITE) || (state == ST_FILLW);
   end

   mem_block_addr_gen #(
      .K (K)
   ) u_addr (
      .clock (clock),
      .reset (reset),
      .load  (accept),
      .down  (desc),
      .len   (len),
      .step  (step),
      .off   (off),
      .last  (last)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mode_q <= MODE_COPY;
         src_q  <= '0;
         dst_q  <= '0;
         fill_q <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (accept) begin
            mode_q <= mode;
            src_q  <= src;
            dst_q  <= dst;
            fill_q <= fill_value;
            err_q  <= !len_zero && range_bad;
         end
         if (state == ST_READ) begin
            data_q <= mem_rd;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               if (len_zero || range_bad) begin
                  state_nxt = ST_FIN;
               end else if (mode == MODE_FILL) begin
                  state_nxt = ST_FILLW;
               end else begin
                  state_nxt = ST_READ;
               end
            end
         end
         ST_READ:  state_nxt = ST_WRITE;
         ST_WRITE: state_nxt = last ? ST_FIN : ST_READ;
         ST_FILLW: state_nxt = last ? ST_FIN : ST_FILLW;
         ST_FIN:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decode registered state only; start never reaches mem_we.
   always_comb begin
      busy   = 1'b0;
      done   = 1'b0;
      err    = 1'b0;
      mem_a  = '0;
      mem_wd = '0;
      mem_we = 1'b0;
      unique case (state)
         ST_READ: begin
            busy  = 1'b1;
            mem_a = src_q + off;
         end
         ST_WRITE: begin
            busy   = 1'b1;
            mem_a  = dst_q + off;
            mem_wd = data_q;
            mem_we = 1'b1;
         end
         ST_FILLW: begin
            busy   = 1'b1;
            mem_a  = dst_q + off;
            mem_wd = fill_q;
            mem_we = 1'b1;
         end
         ST_FIN: begin
            done = 1'b1;
            err  = err_q;
         end
         default: ;
      endcase
   end

   logic unused;
   assign unused = mode_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover with an attached 2^11 x 8 memory.
// Table of commands plus reset-abort and start-while-busy sequences.
module tb_mem_block_mover;

   localparam int M = 8;
   localparam int K = 11;
   localparam int W = 1 << K;

   logic         clock;
   logic         reset;
   logic         start;
   logic         mode;
   logic [K-1:0] src;
   logic [K-1:0] dst;
   logic [K:0]   len;
   logic [M-1:0] fill_value;
   logic         busy;
   logic         done;
   logic         err;
   logic [K-1:0] mem_a;
   logic [M-1:0] mem_wd;
   logic         mem_we;
   logic [M-1:0] mem_rd;

   logic [M-1:0] mem [W];
   logic [M-1:0] exp_mem [W];
   logic         pl_we;
   logic [K-1:0] pl_a;
   logic [M-1:0] pl_d;

   int checks;
   int failures;

   mem_block_mover #(.M(M), .K(K)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .mode       (mode),
      .src        (src),
      .dst        (dst),
      .len        (len),
      .fill_value (fill_value),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_we     (mem_we),
      .mem_rd     (mem_rd)
   );

   always @(posedge clock) begin
      if (pl_we) mem[pl_a] <= pl_d;
      else if (mem_we) mem[mem_a] <= mem_wd;
   end
   assign mem_rd = mem[mem_a];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic        md;
      logic [10:0] s;
      logic [10:0] d;
      logic [11:0] l;
      logic [7:0]  f;
      logic        exp_err;
      int          exp_busy;
      int          exp_we;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_mem(input string nm);
      int bad;
      int first;
      bad = 0;
      first = -1;
      for (int a = 0; a < W; a++) begin
         if (mem[a] !== exp_mem[a]) begin
            if (first < 0) first = a;
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL %s: %0d bad words, first at 0x%03h got 0x%02h expected 0x%02h",
                  nm, bad, first, mem[first], exp_mem[first]);
      end
   endtask

   task automatic preload(input logic [10:0] a, input logic [7:0] d);
      @(negedge clock);
      pl_we = 1'b1;
      pl_a = a;
      pl_d = d;
      @(posedge clock);
      #1 pl_we = 1'b0;
   endtask

   task automatic issue(input logic md, input logic [10:0] s,
                        input logic [10:0] d, input logic [11:0] l,
                        input logic [7:0] f);
      @(negedge clock);
      mode = md;
      src = s;
      dst = d;
      len = l;
      fill_value = f;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input bit intr, output int bc, output int wc,
                            output logic e, output bit to);
      bc = 0;
      wc = 0;
      e = 1'b0;
      to = 1'b1;
      if (intr) begin
         mode = 1'b1;
         dst = 11'h700;
         len = 12'd3;
         fill_value = 8'hEE;
         start = 1'b1;
      end
      for (int c = 0; c < 5000; c++) begin
         @(negedge clock);
         if (intr && c == 3) start = 1'b0;
         if (done) begin
            e = err;
            to = 1'b0;
            break;
         end
         if (busy) bc++;
         if (mem_we) wc++;
      end
      start = 1'b0;
   endtask

   task automatic model(input logic md, input logic [10:0] s,
                        input logic [10:0] d, input logic [11:0] l,
                        input logic [7:0] f);
      logic [7:0] tmp [W];
      for (int i = 0; i < int'(l); i++) tmp[i] = exp_mem[(int'(s) + i) % W];
      for (int i = 0; i < int'(l); i++)
         exp_mem[(int'(d) + i) % W] = md ? f : tmp[i];
   endtask

   initial begin
      int   bc;
      int   wc;
      logic e;
      bit   to;

      checks = 0;
      failures = 0;
      reset = 1'b1;
      start = 1'b0;
      mode = 1'b0;
      src = '0;
      dst = '0;
      len = '0;
      fill_value = '0;
      pl_we = 1'b0;
      pl_a = '0;
      pl_d = '0;

      vecs[0] = '{"fill_cross", 1'b1, 11'h000, 11'h3FE, 12'd4,    8'hA5, 1'b0, 4,    4};
      vecs[1] = '{"copy_basic", 1'b0, 11'h010, 11'h500, 12'd3,    8'h00, 1'b0, 6,    3};
      vecs[2] = '{"copy_up_ov", 1'b0, 11'h100, 11'h102, 12'd4,    8'h00, 1'b0, 8,    4};
      vecs[3] = '{"copy_dn_ov", 1'b0, 11'h200, 11'h1FE, 12'd4,    8'h00, 1'b0, 8,    4};
      vecs[4] = '{"copy_range", 1'b0, 11'h7FE, 11'h000, 12'd3,    8'h00, 1'b1, 0,    0};
      vecs[5] = '{"fill_range", 1'b1, 11'h000, 11'h7FF, 12'd2,    8'h11, 1'b1, 0,    0};
      vecs[6] = '{"len_zero",   1'b0, 11'h010, 11'h020, 12'd0,    8'h00, 1'b0, 0,    0};
      vecs[7] = '{"copy_full",  1'b0, 11'h000, 11'h000, 12'd2048, 8'h00, 1'b0, 4096, 2048};
      vecs[8] = '{"fill_top",   1'b1, 11'h000, 11'h7FC, 12'd4,    8'h3C, 1'b0, 4,    4};

      repeat (2) @(posedge clock);
      for (int a = 0; a < W; a++) preload(11'(a), 8'h00);
      preload(11'h010, 8'd1);
      preload(11'h011, 8'd2);
      preload(11'h012, 8'd3);
      for (int i = 0; i < 4; i++) preload(11'h100 + 11'(i), 8'(i + 1));
      for (int i = 0; i < 4; i++) preload(11'h200 + 11'(i), 8'(i + 5));
      for (int a = 0; a < W; a++) exp_mem[a] = mem[a];

      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      check("rst_we", int'(mem_we), 0);
      check("rst_a", int'(mem_a), 0);
      check("rst_wd", int'(mem_wd), 0);

      for (int v = 0; v < 9; v++) begin
         issue(vecs[v].md, vecs[v].s, vecs[v].d, vecs[v].l, vecs[v].f);
         wait_done(1'b0, bc, wc, e, to);
         check({vecs[v].name, "_timeout"}, int'(to), 0);
         check({vecs[v].name, "_err"}, int'(e), int'(vecs[v].exp_err));
         check({vecs[v].name, "_busy"}, bc, vecs[v].exp_busy);
         check({vecs[v].name, "_we"}, wc, vecs[v].exp_we);
         @(negedge clock);
         check({vecs[v].name, "_idle"}, int'(busy | done), 0);
         if (!vecs[v].exp_err)
            model(vecs[v].md, vecs[v].s, vecs[v].d, vecs[v].l, vecs[v].f);
         check_mem({vecs[v].name, "_mem"});
      end

      // Reset lands after two of five fill words.
      issue(1'b1, 11'h000, 11'h600, 12'd5, 8'h77);
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_we", int'(mem_we), 0);
      check("abort_done", int'(done), 0);
      @(negedge clock);
      reset = 1'b0;
      exp_mem[11'h600] = 8'h77;
      exp_mem[11'h601] = 8'h77;
      @(negedge clock);
      check_mem("abort_mem");

      // Competing FILL strobed while the COPY is running.
      issue(1'b0, 11'h010, 11'h700, 12'd3, 8'h00);
      wait_done(1'b1, bc, wc, e, to);
      check("intr_timeout", int'(to), 0);
      check("intr_err", int'(e), 0);
      check("intr_busy", bc, 6);
      check("intr_we", wc, 3);
      @(negedge clock);
      check("intr_idle", int'(busy | done), 0);
      model(1'b0, 11'h010, 11'h700, 12'd3, 8'h00);
      check_mem("intr_mem");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
